prbs_seq_multi: RTL and testbench

Multi-lane successor to the single-lane PRBS bring-up sequencer. It sits between the transceiver reset/lock logic and NUM_CH GT lanes. After `alldone` it runs a fixed sequence: enable TX PRBS, enable RX PRBS, inject errors for a bounded window, drain, then wait for a clean settle period. Every lane must have detected the injected errors before the block reaches ACTIVE with `prbs_test_pass`. Timeouts are bounded and go to a FAIL state, and a `restart` pulse re-runs the whole test without a full reset.

---
 rtl/prbs_seq_multi.sv | 186 ++++++++++++++++++
 tb/tb_prbs_seq_multi.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_seq_multi.sv
// Purpose : multi-lane PRBS bring-up sequencer; enables TX/RX PRBS, injects errors, drains, settles, reports pass/fail.
// Latency : every output is registered and shows the value for the state being entered; prbs_test_pass is combinational.
// Backpressure: none; lane inputs are levels sampled every cycle, restart is honoured only in ACTIVE or FAIL.
//
// Ports:
//   clk, reset (async, active-high)  alldone (all lanes reset-done)  restart (pulse, ACTIVE/FAIL only)
//   rx_prbs_err[NUM_CH]   per-lane checker error        checker_status[NUM_CH] per-lane not-locked
//   prbscntreset_ext / error_inject_ext    forwarded to prbscntreset / error_inject while ACTIVE
//   tx_prbs_mode / rx_prbs_mode            3 bits per lane, lane i at [3i+2:3i]
//   prbscntreset, error_inject, inject_seen[NUM_CH], err_count[ERRCNT_W*NUM_CH]
//   prbs_test_pass, test_fail, state (debug encoding)
// Build option: define PRBS_ERRCNT_EN to build the per-lane saturating err_count counters;
//   without it err_count is tied to zero and the sequencer is unchanged.
module prbs_seq_multi #(
   parameter int         NUM_CH        = 4,
   parameter logic [2:0] PRBS_MODE     = 3'b001,
   parameter int         INJECT_CYCLES = 1024,
   parameter int         SETTLE_CYCLES = 512,
   parameter int         DRAIN_TIMEOUT = 4096,
   parameter int         ERRCNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alldone,
   input  logic                       restart,
   input  logic [NUM_CH-1:0]          rx_prbs_err,
   input  logic [NUM_CH-1:0]          checker_status,
   input  logic                       prbscntreset_ext,
   input  logic                       error_inject_ext,
   output logic [3*NUM_CH-1:0]        tx_prbs_mode,
   output logic [3*NUM_CH-1:0]        rx_prbs_mode,
   output logic                       prbscntreset,
   output logic                       error_inject,
   output logic [NUM_CH-1:0]          inject_seen,
   output logic [ERRCNT_W*NUM_CH-1:0] err_count,
   output logic                       prbs_test_pass,
   output logic                       test_fail,
   output logic [3:0]                 state
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      WAIT_DONE = 4'd1,
      TX_ON     = 4'd2,
      RX_ON     = 4'd3,
      INJECT    = 4'd4,
      DRAIN     = 4'd5,
      SETTLE    = 4'd6,
      ACTIVE    = 4'd7,
      FAIL      = 4'd8
   } state_t;

   localparam int INJ_W = $clog2(INJECT_CYCLES + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TO_W  = $clog2(DRAIN_TIMEOUT + 1);

   // Last-cycle values: a counter equal to these means the current cycle completes the window.
   localparam logic [INJ_W-1:0] INJ_LAST = INJ_W'(INJECT_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);

   state_t           st;
   state_t           nxt;
   logic [INJ_W-1:0] inj_cnt;
   logic [SET_W-1:0] clean_cnt;
   logic [TO_W-1:0]  to_cnt;

   logic all_clean;
   logic timeout;
   logic restart_ok;
   logic st_window;
   logic nxt_window;
   logic tx_en_n;
   logic rx_en_n;
   logic pcr_n;
   logic ei_n;

   assign all_clean  = ~(|rx_prbs_err) & ~(|checker_status);
   assign timeout    = (to_cnt == TO_LAST);
   assign restart_ok = restart & ((st == ACTIVE) | (st == FAIL));
   // DRAIN and SETTLE share one timeout budget, so the timeout counter spans both.
   assign st_window  = (st == DRAIN) | (st == SETTLE);
   assign nxt_window = (nxt == DRAIN) | (nxt == SETTLE);

   // Next-state logic
   always_comb begin
      nxt = st;
      case (st)
         IDLE:      nxt = WAIT_DONE;
         WAIT_DONE: if (alldone) nxt = TX_ON;
         TX_ON:     nxt = RX_ON;
         RX_ON:     nxt = INJECT;
         INJECT:    if (inj_cnt == INJ_LAST) nxt = DRAIN;
         DRAIN: begin
            if (timeout)                nxt = FAIL;
            else if (~(|rx_prbs_err))   nxt = SETTLE;
         end
         SETTLE: begin
            if (timeout)
               nxt = FAIL;
            else if (all_clean && (clean_cnt == SET_LAST))
               nxt = (&inject_seen) ? ACTIVE : FAIL;
         end
         ACTIVE:    if (restart) nxt = WAIT_DONE;
         FAIL:      if (restart) nxt = WAIT_DONE;
         default:   nxt = IDLE;
      endcase
   end

   // Output values belonging to the state being entered; registered below.
   always_comb begin
      tx_en_n = 1'b0;
      rx_en_n = 1'b0;
      pcr_n   = 1'b0;
      ei_n    = 1'b0;
      case (nxt)
         TX_ON:  tx_en_n = 1'b1;
         RX_ON:  begin tx_en_n = 1'b1; rx_en_n = 1'b1; pcr_n = 1'b1; end
         INJECT: begin tx_en_n = 1'b1; rx_en_n = 1'b1; ei_n = 1'b1; end
         DRAIN:  begin tx_en_n = 1'b1; rx_en_n = 1'b1; end
         SETTLE: begin tx_en_n = 1'b1; rx_en_n = 1'b1; pcr_n = 1'b1; end
         ACTIVE: begin
            tx_en_n = 1'b1;
            rx_en_n = 1'b1;
            pcr_n   = prbscntreset_ext;
            ei_n    = error_inject_ext;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st           <= IDLE;
         inj_cnt      <= '0;
         clean_cnt    <= '0;
         to_cnt       <= '0;
         tx_prbs_mode <= '0;
         rx_prbs_mode <= '0;
         prbscntreset <= 1'b0;
         error_inject <= 1'b0;
         test_fail    <= 1'b0;
         inject_seen  <= '0;
      end else begin
         st        <= nxt;
         inj_cnt   <= ((st == INJECT) && (nxt == INJECT)) ? inj_cnt + 1'b1 : '0;
         // Any dirty cycle restarts the clean run from zero.
         clean_cnt <= ((st == SETTLE) && (nxt == SETTLE) && all_clean) ? clean_cnt + 1'b1 : '0;
         to_cnt    <= (st_window && nxt_window) ? to_cnt + 1'b1 : '0;

         tx_prbs_mode <= tx_en_n ? {NUM_CH{PRBS_MODE}} : '0;
         rx_prbs_mode <= rx_en_n ? {NUM_CH{PRBS_MODE}} : '0;
         prbscntreset <= pcr_n;
         error_inject <= ei_n;
         test_fail    <= (nxt == FAIL);

         // Only errors seen while INJECT is the current state count; the first DRAIN cycle does not.
         if (restart_ok || (nxt == RX_ON))
            inject_seen <= '0;
         else if (st == INJECT)
            inject_seen <= inject_seen | rx_prbs_err;
      end
   end

`ifdef PRBS_ERRCNT_EN
   // Clear has priority over counting; counts hold at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (restart_ok || prbscntreset)
               err_count[i*ERRCNT_W +: ERRCNT_W] <= '0;
            else if ((st == ACTIVE) && rx_prbs_err[i] && ~(&err_count[i*ERRCNT_W +: ERRCNT_W]))
               err_count[i*ERRCNT_W +: ERRCNT_W] <= err_count[i*ERRCNT_W +: ERRCNT_W] + 1'b1;
         end
      end
   end
`else
   assign err_count = '0;
`endif

   assign prbs_test_pass = (st == ACTIVE) & (&inject_seen);
   assign state          = st;

endmodule

// File: tb/tb_prbs_seq_multi.sv
// Bench for prbs_seq_multi: a cycle model derived from the sequence rules is compared against the DUT every
// cycle, and directed scenarios pin latencies and end states with hand-computed literals.
module tb_prbs_seq_multi;

   localparam int INJ = 16;
   localparam int SET = 8;
   localparam int TO  = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        alldone = 1'b0;
   logic        restart = 1'b0;
   logic [3:0]  rx_prbs_err = 4'h0;
   logic [3:0]  checker_status = 4'h0;
   logic        prbscntreset_ext = 1'b0;
   logic        error_inject_ext = 1'b0;
   logic [11:0] tx_prbs_mode;
   logic [11:0] rx_prbs_mode;
   logic        prbscntreset;
   logic        error_inject;
   logic [3:0]  inject_seen;
   logic [63:0] err_count;
   logic        prbs_test_pass;
   logic        test_fail;
   logic [3:0]  state;

   int checks = 0;
   int errors = 0;
   int n;

   prbs_seq_multi #(
      .NUM_CH(4), .PRBS_MODE(3'b001), .INJECT_CYCLES(INJ),
      .SETTLE_CYCLES(SET), .DRAIN_TIMEOUT(TO), .ERRCNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .alldone(alldone), .restart(restart),
      .rx_prbs_err(rx_prbs_err), .checker_status(checker_status),
      .prbscntreset_ext(prbscntreset_ext), .error_inject_ext(error_inject_ext),
      .tx_prbs_mode(tx_prbs_mode), .rx_prbs_mode(rx_prbs_mode),
      .prbscntreset(prbscntreset), .error_inject(error_inject),
      .inject_seen(inject_seen), .err_count(err_count),
      .prbs_test_pass(prbs_test_pass), .test_fail(test_fail), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // State numbers follow the published debug encoding. m_age = cycles already spent in the
   // current state, m_win = cycles since DRAIN was entered, m_run = length of the current clean run.
   int         m_st = 0;
   int         m_age = 0;
   int         m_win = 0;
   int         m_run = 0;
   logic [3:0] m_seen = 4'h0;
   int         m_cnt [4];
   logic       m_pcr = 1'b0;
   logic       m_ei = 1'b0;
   int         nx;
   logic       acc_restart;
   logic       clean_now;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_st = 0; m_age = 0; m_win = 0; m_run = 0;
         m_seen = 4'h0; m_pcr = 1'b0; m_ei = 1'b0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
         acc_restart = restart && (m_st == 7 || m_st == 8);
         clean_now   = (rx_prbs_err == 4'h0) && (checker_status == 4'h0);
         nx = m_st;
         if (m_st == 0) nx = 1;
         else if (m_st == 1) nx = alldone ? 2 : 1;
         else if (m_st == 2) nx = 3;
         else if (m_st == 3) nx = 4;
         else if (m_st == 4) nx = (m_age + 1 >= INJ) ? 5 : 4;
         else if (m_st == 5 || m_st == 6) begin
            if (m_win + 1 >= TO) nx = 8;
            else if (m_st == 5) nx = (rx_prbs_err == 4'h0) ? 6 : 5;
            else if (clean_now && m_run + 1 >= SET) nx = (m_seen == 4'hF) ? 7 : 8;
         end
         else if (m_st == 7 || m_st == 8) nx = acc_restart ? 1 : m_st;
         else nx = 0;

         for (int i = 0; i < 4; i++) begin
            if (acc_restart || m_pcr) m_cnt[i] = 0;
            else if (m_st == 7 && rx_prbs_err[i] && m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
         end
         if (acc_restart || nx == 3) m_seen = 4'h0;
         else if (m_st == 4) m_seen = m_seen | rx_prbs_err;

         m_run = (m_st == 6 && nx == 6 && clean_now) ? m_run + 1 : 0;
         m_win = ((m_st == 5 || m_st == 6) && (nx == 5 || nx == 6)) ? m_win + 1 : 0;
         m_age = (nx == m_st) ? m_age + 1 : 0;
         m_pcr = (nx == 3 || nx == 6) ? 1'b1 : ((nx == 7) ? prbscntreset_ext : 1'b0);
         m_ei  = (nx == 4) ? 1'b1 : ((nx == 7) ? error_inject_ext : 1'b0);
         m_st  = nx;
      end
   end

   logic [63:0] m_ec;
   always @(negedge clk) begin
`ifdef PRBS_ERRCNT_EN
      m_ec = {m_cnt[3][15:0], m_cnt[2][15:0], m_cnt[1][15:0], m_cnt[0][15:0]};
`else
      m_ec = 64'h0;
`endif
      check("m_state", state, m_st);
      check("m_tx", tx_prbs_mode, (m_st >= 2 && m_st <= 7) ? 12'h249 : 12'h0);
      check("m_rx", rx_prbs_mode, (m_st >= 3 && m_st <= 7) ? 12'h249 : 12'h0);
      check("m_pcr", prbscntreset, m_pcr);
      check("m_ei", error_inject, m_ei);
      check("m_seen", inject_seen, m_seen);
      check("m_errcnt", err_count, m_ec);
      check("m_pass", prbs_test_pass, (m_st == 7) && (m_seen == 4'hF));
      check("m_fail", test_fail, m_st == 8);
   end

   // ---------------- stimulus ----------------
   // Starts in WAIT_DONE with alldone high. n = clock edges taken. All lanes in 'pulse' error
   // for 2 cycles mid-INJECT, 'stuck' lanes hold their error from then on, checker_status[1]
   // pulses for the cycle numbered glitch_at, and a restart pulse mid-INJECT must be ignored.
   task automatic run_seq(input logic [3:0] pulse, input logic [3:0] stuck, input int glitch_at,
                          input logic [3:0] stop_st, output int edges);
      edges = 0;
      while (edges < 200) begin
         @(posedge clk); #1;
         edges++;
         if (state == stop_st) break;
         rx_prbs_err    = ((edges >= 8 && edges < 10) ? pulse : 4'h0) | ((edges >= 8) ? stuck : 4'h0);
         checker_status = (edges == glitch_at) ? 4'b0010 : 4'h0;
         restart        = (edges == 12);
      end
      rx_prbs_err = 4'h0; checker_status = 4'h0; restart = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
   endtask

   logic [63:0] exp_ec5;

   initial begin
`ifdef PRBS_ERRCNT_EN
      exp_ec5 = {16'd5, 48'd0};
`else
      exp_ec5 = 64'd0;
`endif
      repeat (3) @(posedge clk); #1;
      check("rst_state", state, 4'd0);
      check("rst_modes", {tx_prbs_mode, rx_prbs_mode}, 24'h0);
      check("rst_flags", {prbscntreset, error_inject, test_fail, prbs_test_pass}, 4'h0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_to_wait", state, 4'd1);
      repeat (3) @(posedge clk); #1;
      check("wait_holds", state, 4'd1);

      // Nominal: 1+1+1+16+1+8 edges from alldone to ACTIVE
      alldone = 1'b1;
      run_seq(4'hF, 4'h0, -1, 4'd7, n);
      check("nom_latency", n, 28);
      check("nom_seen", inject_seen, 4'hF);
      check("nom_pass", prbs_test_pass, 1'b1);
      check("nom_tx", tx_prbs_mode, 12'h249);

      // ACTIVE: 5 error cycles on lane 3, then error_inject pass-through
      rx_prbs_err = 4'b1000;
      repeat (5) @(posedge clk); #1;
      rx_prbs_err = 4'h0;
      @(posedge clk); #1;
      check("errcnt_lane3", err_count, exp_ec5);
      error_inject_ext = 1'b1;
      @(posedge clk); #1;
      check("ei_passthru", error_inject, 1'b1);
      error_inject_ext = 1'b0;
      @(posedge clk); #1;
      check("ei_drop", error_inject, 1'b0);
      pulse_restart();
      check("restart_state", state, 4'd1);
      check("restart_seen", inject_seen, 4'h0);
      check("restart_errcnt", err_count, 64'h0);
      check("restart_pass", prbs_test_pass, 1'b0);

      // Dead lane 2
      run_seq(4'hB, 4'h0, -1, 4'd8, n);
      check("dead_latency", n, 28);
      check("dead_seen", inject_seen, 4'hB);
      check("dead_pass", prbs_test_pass, 1'b0);
      check("dead_fail", test_fail, 1'b1);
      pulse_restart();
      check("dead_restart", state, 4'd1);

      // Stuck lane 0: DRAIN entered at edge 19, FAIL 32 edges later
      run_seq(4'hF, 4'h1, -1, 4'd8, n);
      check("stuck_latency", n, 51);
      check("stuck_modes", {tx_prbs_mode, rx_prbs_mode}, 24'h0);
      pulse_restart();

      // Settle glitch at clean count 6 (cycle 26); ACTIVE 8 edges after it ends
      run_seq(4'hF, 4'h0, 26, 4'd7, n);
      check("glitch_latency", n, 35);
      check("glitch_pass", prbs_test_pass, 1'b1);
      pulse_restart();

      // Async reset during INJECT
      repeat (6) @(posedge clk); #1;
      rx_prbs_err = 4'hF;
      repeat (2) @(posedge clk); #1;
      check("pre_reset_state", state, 4'd4);
      check("pre_reset_seen", inject_seen, 4'hF);
      reset = 1'b1;
      #1;
      check("async_state", state, 4'd0);
      check("async_outs", {tx_prbs_mode, rx_prbs_mode, error_inject, prbscntreset, inject_seen}, 30'h0);
      rx_prbs_err = 4'h0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_reset_wait", state, 4'd1);
      run_seq(4'hF, 4'h0, -1, 4'd7, n);
      check("post_reset_latency", n, 28);
      check("post_reset_pass", prbs_test_pass, 1'b1);

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
